// File: rtl/cpu_dma_tx_ctrl_pkg.sv
// Shared definitions for the CPU DMA TX controller: FSM state encoding,
// the default FIFO word size and a constant log2 helper (also used by the
// queue register block).
package cpu_dma_tx_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_DONE  = 2'd2,
      ST_ABORT = 2'd3
   } tx_state_t;

   localparam int DEFAULT_DATA_BYTES = 8;

   // Ceiling log2 for elaboration-time constants; clog2_f(1) = 0.
   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cpu_dma_tx_watchdog.sv
// Per-packet inactivity watchdog. Counts cycles in which the transfer is
// running without progress; expire_next flags the cycle whose lack of
// progress must end the packet. The owning FSM leaves XFER on expiry, so the
// counter never has to wrap.
module cpu_dma_tx_watchdog
   import cpu_dma_tx_ctrl_pkg::*;
#(
   parameter int TX_WATCHDOG_TIMEOUT = 125000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expire_next
);

   localparam int WD_W = clog2_f(TX_WATCHDOG_TIMEOUT + 1);

   logic [WD_W-1:0] r_count;

   // Idle-cycle counter: clear has priority over counting.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (run) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign expire_next = run && (r_count == WD_W'(TX_WATCHDOG_TIMEOUT - 1));

endmodule

// File: rtl/cpu_dma_tx_ctrl.sv
// CPU-to-NetFPGA DMA TX packet sequencer. Latches the packet length, gates
// word writes into the TX FIFO against backpressure, marks end-of-packet and
// aborts a stalled packet through the inactivity watchdog.
// Optional macro CPU_DMA_TX_CTRL_STATS_EN enables the completed-packet
// counter on tx_pkt_cnt; without it tx_pkt_cnt is constant 0.
//
// Handshake: a word moves from the DMA engine to the FIFO in exactly the
// cycles where dma_tx_wr_valid && dma_tx_wr_ready are both high. ready
// depends only on state and fifo_full (never on valid), valid may be
// raised or dropped freely, and the write happens in that same cycle.
module cpu_dma_tx_ctrl
   import cpu_dma_tx_ctrl_pkg::*;
#(
   parameter int TX_WATCHDOG_TIMEOUT = 125000,
   parameter int LEN_WIDTH           = 12,
   parameter int DATA_BYTES          = DEFAULT_DATA_BYTES
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 dma_tx_start,
   input  logic [LEN_WIDTH-1:0] dma_tx_len,
   input  logic                 dma_tx_wr_valid,
   output logic                 dma_tx_wr_ready,
   input  logic                 fifo_full,
   output logic                 fifo_wr_en,
   output logic                 fifo_wr_eop,
   output logic                 fifo_drop,
   output logic                 tx_timeout,
   output logic                 dma_tx_busy,
   output logic                 dma_tx_done,
   output logic [31:0]          tx_pkt_cnt,
   output logic [1:0]           dbg_state
);

   localparam int LOG2_DB = clog2_f(DATA_BYTES);
   localparam int WL_W    = LEN_WIDTH + 1;

   tx_state_t       r_state;
   logic [WL_W-1:0] r_words_left;

   logic [WL_W-1:0] w_len_ext;
   logic [WL_W-1:0] w_words;
   logic            w_start_ok;
   logic            w_accept;
   logic            w_last;
   logic            w_wd_clear;
   logic            w_wd_run;
   logic            w_wd_expire;

   // Word count rounded up; the extra bit keeps len + DATA_BYTES-1 exact.
   assign w_len_ext  = {1'b0, dma_tx_len};
   assign w_words    = (w_len_ext + WL_W'(DATA_BYTES - 1)) >> LOG2_DB;

   assign w_start_ok = (r_state == ST_IDLE) && dma_tx_start && (dma_tx_len != '0);
   assign w_accept   = dma_tx_wr_valid && dma_tx_wr_ready;
   assign w_last     = (r_words_left == WL_W'(1));

   assign w_wd_clear = w_start_ok || w_accept;
   assign w_wd_run   = (r_state == ST_XFER) && !w_accept;

   cpu_dma_tx_watchdog #(
      .TX_WATCHDOG_TIMEOUT (TX_WATCHDOG_TIMEOUT)
   ) u_watchdog (
      .clk         (clk),
      .reset       (reset),
      .clear       (w_wd_clear),
      .run         (w_wd_run),
      .expire_next (w_wd_expire)
   );

   // Packet FSM and remaining-word counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_words_left <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start_ok) begin
                  r_words_left <= w_words;
                  r_state      <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (w_accept) begin
                  r_words_left <= r_words_left - 1'b1;
                  if (w_last) r_state <= ST_DONE;
               end else if (w_wd_expire) begin
                  r_state <= ST_ABORT;
               end
            end
            ST_DONE:  r_state <= ST_IDLE;
            ST_ABORT: r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   // Status pulses decode straight from the state register, so they are
   // clean one-cycle pulses with no combinational input path.
   assign dma_tx_busy     = (r_state == ST_XFER);
   assign dma_tx_done     = (r_state == ST_DONE);
   assign tx_timeout      = (r_state == ST_ABORT);
   assign fifo_drop       = (r_state == ST_ABORT);
   assign dma_tx_wr_ready = dma_tx_busy && !fifo_full;
   assign fifo_wr_en      = w_accept;
   assign fifo_wr_eop     = w_accept && w_last;
   assign dbg_state       = r_state;

`ifdef CPU_DMA_TX_CTRL_STATS_EN
   logic [31:0] r_pkt_cnt;

   // Completed-packet counter; wraps naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pkt_cnt <= '0;
      end else if (r_state == ST_DONE) begin
         r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
   end

   assign tx_pkt_cnt = r_pkt_cnt;
`else
   assign tx_pkt_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_dma_tx_ctrl.sv
// Bench for cpu_dma_tx_ctrl with a short watchdog (16 cycles). Honours
// CPU_DMA_TX_CTRL_STATS_EN in the same way as the design.
module tb_cpu_dma_tx_ctrl;

   localparam int TMO = 16;
   localparam int LW  = 12;
   localparam int DB  = 8;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          dma_tx_start = 1'b0;
   logic [LW-1:0] dma_tx_len = '0;
   logic          dma_tx_wr_valid = 1'b0;
   logic          dma_tx_wr_ready;
   logic          fifo_full = 1'b0;
   logic          fifo_wr_en;
   logic          fifo_wr_eop;
   logic          fifo_drop;
   logic          tx_timeout;
   logic          dma_tx_busy;
   logic          dma_tx_done;
   logic [31:0]   tx_pkt_cnt;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   cpu_dma_tx_ctrl #(
      .TX_WATCHDOG_TIMEOUT (TMO),
      .LEN_WIDTH           (LW),
      .DATA_BYTES          (DB)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .dma_tx_start    (dma_tx_start),
      .dma_tx_len      (dma_tx_len),
      .dma_tx_wr_valid (dma_tx_wr_valid),
      .dma_tx_wr_ready (dma_tx_wr_ready),
      .fifo_full       (fifo_full),
      .fifo_wr_en      (fifo_wr_en),
      .fifo_wr_eop     (fifo_wr_eop),
      .fifo_drop       (fifo_drop),
      .tx_timeout      (tx_timeout),
      .dma_tx_busy     (dma_tx_busy),
      .dma_tx_done     (dma_tx_done),
      .tx_pkt_cnt      (tx_pkt_cnt),
      .dbg_state       (dbg_state)
   );

   // ---------------- scoreboard counters ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A packet is "in flight" with a number of words still owed and a count of
   // consecutive cycles without progress; completion/abort each show a
   // one-cycle pulse in the cycle after the deciding edge.
   bit          m_in_flight = 0;
   int          m_owed = 0;
   int          m_stall = 0;
   bit          m_done_pulse = 0;
   bit          m_abort_pulse = 0;
   int unsigned m_pkts = 0;
   logic [31:0] exp_q[$];   // words per started packet, popped on each EOP

   // Event tallies of what the DUT actually did, for the directed literals.
   int tot_wr = 0, tot_eop = 0, tot_done = 0, tot_to = 0, tot_idle = 0;

   // Compare every cycle mid-period, then advance the model over the edge.
   always @(negedge clk) begin
      bit exp_ready, exp_acc, exp_eop, nd, na;
      exp_ready = m_in_flight && !fifo_full;
      exp_acc   = exp_ready && dma_tx_wr_valid;
      exp_eop   = exp_acc && (m_owed == 1);

      chk("wr_ready",   {31'd0, dma_tx_wr_ready}, {31'd0, exp_ready});
      chk("fifo_wr_en", {31'd0, fifo_wr_en},      {31'd0, exp_acc});
      chk("fifo_eop",   {31'd0, fifo_wr_eop},     {31'd0, exp_eop});
      chk("busy",       {31'd0, dma_tx_busy},     {31'd0, m_in_flight});
      chk("done",       {31'd0, dma_tx_done},     {31'd0, m_done_pulse});
      chk("tx_timeout", {31'd0, tx_timeout},      {31'd0, m_abort_pulse});
      chk("fifo_drop",  {31'd0, fifo_drop},       {31'd0, m_abort_pulse});
`ifdef CPU_DMA_TX_CTRL_STATS_EN
      chk("pkt_cnt", tx_pkt_cnt, m_pkts);
`else
      chk("pkt_cnt", tx_pkt_cnt, 32'd0);
`endif

      if (fifo_wr_en) tot_wr++;
      if (fifo_wr_eop) begin
         tot_eop++;
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (dma_tx_done) tot_done++;
      if (tx_timeout) tot_to++;
      if (dma_tx_busy && !fifo_wr_en) tot_idle++;

      if (reset) begin
         m_in_flight = 0; m_owed = 0; m_stall = 0;
         m_done_pulse = 0; m_abort_pulse = 0; m_pkts = 0;
         exp_q.delete();
      end else begin
         nd = exp_eop;
         na = m_in_flight && !exp_acc && (m_stall == TMO - 1);
         if (m_done_pulse) m_pkts++;
         if (m_in_flight) begin
            if (exp_acc) begin
               m_owed--;
               m_stall = 0;
               if (m_owed == 0) m_in_flight = 0;
            end else begin
               m_stall++;
               if (m_stall == TMO) m_in_flight = 0;
            end
         end else if (!m_done_pulse && !m_abort_pulse && dma_tx_start && dma_tx_len != 0) begin
            m_in_flight = 1;
            m_owed = (int'(dma_tx_len) + DB - 1) / DB;
            m_stall = 0;
            exp_q.push_back(32'(m_owed));
         end
         m_done_pulse  = nd;
         m_abort_pulse = na;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic start_pkt(input int len);
      dma_tx_start = 1'b1;
      dma_tx_len   = LW'(len);
      cyc();
      dma_tx_start = 1'b0;
   endtask

   task automatic wait_wr(input int base, input int n);
      for (int i = 0; i < 60 && (tot_wr - base) < n; i++) cyc();
      chk("wait_wr", 32'(tot_wr - base), 32'(n));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int bw, be, bd, bt, bi;
      int vprob, fprob;

      repeat (3) cyc();
      reset = 1'b0;
      cyc();

      // Completion: 20 bytes -> 3 words, EOP on the third.
      bw = tot_wr; be = tot_eop; bd = tot_done; bt = tot_to;
      dma_tx_wr_valid = 1'b1;
      start_pkt(20);
      repeat (6) cyc();
      chk("t1_words", 32'(tot_wr - bw), 32'd3);
      chk("t1_eop",   32'(tot_eop - be), 32'd1);
      chk("t1_done",  32'(tot_done - bd), 32'd1);
      chk("t1_to",    32'(tot_to - bt), 32'd0);
`ifdef CPU_DMA_TX_CTRL_STATS_EN
      chk("t1_cnt", tx_pkt_cnt, 32'd1);
`else
      chk("t1_cnt", tx_pkt_cnt, 32'd0);
`endif

      // Backpressure: 64 bytes -> 8 words, 5-cycle FIFO stall after word 2.
      bw = tot_wr; be = tot_eop; bd = tot_done; bt = tot_to;
      start_pkt(64);
      wait_wr(bw, 2);
      fifo_full = 1'b1;
      repeat (5) cyc();
      chk("t2_stall_words", 32'(tot_wr - bw), 32'd2);
      fifo_full = 1'b0;
      repeat (10) cyc();
      chk("t2_words", 32'(tot_wr - bw), 32'd8);
      chk("t2_eop",   32'(tot_eop - be), 32'd1);
      chk("t2_done",  32'(tot_done - bd), 32'd1);
      chk("t2_to",    32'(tot_to - bt), 32'd0);

      // Watchdog expiry: valid drops after word 1.
      bw = tot_wr; bd = tot_done; bt = tot_to;
      start_pkt(64);
      wait_wr(bw, 1);
      dma_tx_wr_valid = 1'b0;
      bi = tot_idle;
      repeat (25) cyc();
      chk("t3_idle",  32'(tot_idle - bi), 32'd16);
      chk("t3_to",    32'(tot_to - bt), 32'd1);
      chk("t3_done",  32'(tot_done - bd), 32'd0);
      chk("t3_words", 32'(tot_wr - bw), 32'd1);

      // Terminal-cycle race, twice: accept lands in the 16th idle cycle.
      bw = tot_wr; bd = tot_done; bt = tot_to;
      dma_tx_wr_valid = 1'b1;
      start_pkt(64);
      wait_wr(bw, 1);
      dma_tx_wr_valid = 1'b0;
      repeat (15) cyc();
      dma_tx_wr_valid = 1'b1;
      cyc();
      dma_tx_wr_valid = 1'b0;
      repeat (15) cyc();
      dma_tx_wr_valid = 1'b1;
      repeat (12) cyc();
      chk("t4_to",    32'(tot_to - bt), 32'd0);
      chk("t4_words", 32'(tot_wr - bw), 32'd8);
      chk("t4_done",  32'(tot_done - bd), 32'd1);

      // Ignored starts: len 0 in IDLE, and a second start mid-transfer.
      bw = tot_wr; bd = tot_done;
      start_pkt(0);
      repeat (3) cyc();
      chk("t5_len0", 32'(tot_wr - bw), 32'd0);
      start_pkt(24);
      dma_tx_start = 1'b1;
      dma_tx_len   = LW'(8);
      cyc();
      dma_tx_start = 1'b0;
      repeat (8) cyc();
      chk("t5_words", 32'(tot_wr - bw), 32'd3);
      chk("t5_done",  32'(tot_done - bd), 32'd1);

      // Reset after 2 of 5 words, then a clean 1-word packet.
      bw = tot_wr; bt = tot_to;
      start_pkt(40);
      wait_wr(bw, 2);
      dma_tx_wr_valid = 1'b0;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("t6_words", 32'(tot_wr - bw), 32'd2);
      chk("t6_drop",  32'(tot_to - bt), 32'd0);
      bw = tot_wr; be = tot_eop; bd = tot_done;
      dma_tx_wr_valid = 1'b1;
      start_pkt(8);
      repeat (4) cyc();
      chk("t6b_words", 32'(tot_wr - bw), 32'd1);
      chk("t6b_eop",   32'(tot_eop - be), 32'd1);
      chk("t6b_done",  32'(tot_done - bd), 32'd1);

      // Random traffic in segments of differing valid/full pressure.
      for (int s = 0; s < 40; s++) begin
         case ($urandom_range(0, 3))
            0: vprob = 95;
            1: vprob = 60;
            2: vprob = 25;
            default: vprob = 0;
         endcase
         fprob = $urandom_range(0, 40);
         for (int c = 0; c < 40; c++) begin
            dma_tx_start    = ($urandom_range(0, 99) < 30);
            dma_tx_len      = ($urandom_range(0, 9) == 0) ? LW'(0) : LW'($urandom_range(1, 100));
            dma_tx_wr_valid = ($urandom_range(0, 99) < vprob);
            fifo_full       = ($urandom_range(0, 99) < fprob);
            reset           = ($urandom_range(0, 499) == 0);
            cyc();
         end
      end
      dma_tx_start = 1'b0;
      reset = 1'b0;
      repeat (3) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_dma_tx_ctrl.md
Name: cpu_dma_tx_ctrl

Overview:
Sequences one CPU-to-NetFPGA DMA TX packet transfer into the CPU DMA queue's TX FIFO.
- Latches the packet length from the DMA engine and gates word writes against FIFO backpressure.
- Marks end-of-packet on the last word.
- Runs a per-packet inactivity watchdog. On expiry it aborts the packet, tells the FIFO to drop it, and pulses tx_timeout into cpu_dma_queue_regs, which counts the pulses.

Parameters:
TX_WATCHDOG_TIMEOUT, 125000, consecutive XFER cycles with no accepted word before abort (must be >= 2).
LEN_WIDTH, 12, width of packet byte length.
DATA_BYTES, 8, bytes per FIFO word (power of 2).

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
dma_tx_start  in  1  one-cycle request to begin a packet
dma_tx_len  in  LEN_WIDTH  packet length in bytes; valid with dma_tx_start
dma_tx_wr_valid  in  1  DMA engine presents a data word
dma_tx_wr_ready  out  1  controller accepts the word this cycle
fifo_full  in  1  TX FIFO cannot take a word
fifo_wr_en  out  1  write presented word to FIFO
fifo_wr_eop  out  1  word being written is last of packet
fifo_drop  out  1  one-cycle pulse; FIFO discards partial packet
tx_timeout  out  1  one-cycle pulse to cpu_dma_queue_regs on watchdog expiry
dma_tx_busy  out  1  transfer in progress (XFER state)
dma_tx_done  out  1  one-cycle pulse on successful completion
tx_pkt_cnt  out  32  completed-packet count (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset state: FSM in IDLE; words_left=0; watchdog=0. All outputs are 0, including tx_pkt_cnt.
- Reset mid-transfer: the partial packet is abandoned silently; no fifo_drop is generated. The FIFO is reset by the same reset.
- Word count: on start, words_left = ceil(dma_tx_len/DATA_BYTES), computed as (len + DATA_BYTES-1) >> log2(DATA_BYTES) at LEN_WIDTH+1 bits. There is no overflow.
- IDLE:
  - dma_tx_start with len!=0 latches words_left and clears the watchdog; next state is XFER.
  - dma_tx_start with len==0 is ignored and the FSM stays in IDLE.
  - dma_tx_wr_ready=0 in IDLE.
- XFER:
  - dma_tx_busy=1.
  - dma_tx_wr_ready = !fifo_full, combinational.
  - Accept = dma_tx_wr_valid && dma_tx_wr_ready. fifo_wr_en = accept, in the same cycle, zero latency.
  - On accept: words_left decrements and the watchdog clears to 0.
  - fifo_wr_eop = accept && words_left==1. On that accept, next state is DONE.
  - With no accept (valid low or FIFO full), the watchdog increments.
  - If watchdog == TX_WATCHDOG_TIMEOUT-1 and there is no accept, next state is ABORT.
  - An accept in the terminal watchdog cycle wins: no abort.
- DONE: one cycle. dma_tx_done=1. Next state IDLE.
- ABORT: one cycle. tx_timeout=1 and fifo_drop=1. Next state IDLE.
- dma_tx_start while not in IDLE (XFER/DONE/ABORT) is ignored, and its length is not latched.
- Back-to-back start: a new packet can start in the IDLE cycle immediately after DONE or ABORT.
- Watchdog width: log2(TX_WATCHDOG_TIMEOUT+1) bits. It saturates by construction because the FSM leaves XFER.
- Output registering: tx_timeout, fifo_drop and dma_tx_done are decoded from registered state. They are glitch-free.

Optional Feature:
CPU_DMA_TX_CTRL_STATS_EN
- Defined: a 32-bit tx_pkt_cnt increments once per DONE state and wraps from 0xFFFF_FFFF to 0. Aborted packets are not counted. The counter clears on reset.
- Undefined: tx_pkt_cnt is tied to 0 and no counter logic is synthesized.

Decomposition:
- Shared package/define file holds:
  - FSM state encodings: IDLE=0, XFER=1, DONE=2, ABORT=3, 2-bit.
  - The DATA_BYTES default.
  - The log2 function, shared with the regs block.
- Sub-module cpu_dma_tx_watchdog. Inputs: clk, reset, clear, run. Output: expire_next, asserted when count==TIMEOUT-1 && run. Parameter: TX_WATCHDOG_TIMEOUT.
- Top-level holds the FSM, the length counter and the stats counter.

Test Plan:
- Packet completion, TIMEOUT=16: start len=20, valid held high, fifo_full=0 -> 3 accepts on consecutive cycles. fifo_wr_eop on the 3rd only. dma_tx_done one cycle later. busy low after. Stats: tx_pkt_cnt=1.
- FIFO backpressure, TIMEOUT=16: len=64 with fifo_full high for 5 cycles after word 2 -> ready=0 and fifo_wr_en=0 during the stall. No tx_timeout. 8 words written, EOP on the 8th.
- Watchdog expiry, TIMEOUT=16: len=64, valid drops after word 1 -> exactly 16 idle XFER cycles. Then tx_timeout=fifo_drop=1 for one cycle. Back to IDLE, no dma_tx_done. Stats: count unchanged.
- Terminal-cycle race: accept in the 16th idle cycle -> no abort, watchdog cleared.
- Ignored starts: start len=0 in IDLE -> stays IDLE. Start len=8 during XFER -> ignored, and the original word count completes unchanged.
- Reset mid-XFER after 2 of 5 words -> all outputs 0 next cycle. A following start len=8 completes normally with 1 word and EOP.
